// File: rtl/perf_scan_ctrl_pkg.sv
// Shared types and widths for the perf counter scan controller.
package perf_scan_ctrl_pkg;

  localparam int PERF_ADDR_W = 8;
  localparam int PERF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    EMIT,
    DONE
  } scan_state_t;

  typedef struct packed {
    logic [PERF_ADDR_W-1:0] addr;
    logic [PERF_DATA_W-1:0] data;
    logic                   timeout;
  } perf_rec_t;

endpackage

// File: rtl/perf_scan_ctrl_if.sv
// perf counter bus: one master strobes an address, slaves answer with ack/data
// (data is OR-combined, so idle slaves drive zero) or hold off with stall.
interface perf_scan_ctrl_if;
  import perf_scan_ctrl_pkg::*;

  logic [PERF_ADDR_W-1:0] addr;
  logic                   stb;
  logic                   ack;
  logic                   stall;
  logic [PERF_DATA_W-1:0] data;

  modport master (output addr, output stb, input ack, input data, input stall);
  modport slave  (input addr, input stb, output ack, output data, output stall);
endinterface

// File: rtl/perf_scan_ctrl_timer.sv
// Read timeout down-counter: load TIMEOUT-1 when a read is issued, count while
// waiting, expired once the count reaches zero.
module perf_scan_ctrl_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_count,
  output logic o_expired
);
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load takes priority, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = CNT_W'(TIMEOUT - 1);
    end else if (i_count && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_expired = (cnt_q == '0);
endmodule

// File: rtl/perf_scan_ctrl.sv
// Scans perf counters BASE_ADDR..BASE_ADDR+N_COUNTERS-1 one read at a time and
// streams {addr, data, timeout} records on a valid/ready port.
// Optional build macro PERF_SCAN_DELTA_EN: report cur - prev per counter
// instead of the raw value.
//
// state | meaning
// IDLE  | waiting for i_start
// REQ   | stb asserted with current address, held while slave stalls
// WAIT  | waiting for ack, abandoned after TIMEOUT cycles
// EMIT  | record valid, held until the sink accepts it
// DONE  | one-cycle completion pulse
module perf_scan_ctrl
  import perf_scan_ctrl_pkg::*;
#(
  parameter int N_COUNTERS = 16,
  parameter int BASE_ADDR  = 0,
  parameter int TIMEOUT    = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [PERF_ADDR_W-1:0] o_addr,
  output logic [PERF_DATA_W-1:0] o_data,
  output logic                   o_timeout,
  perf_scan_ctrl_if.master       perf
);
  localparam int IDX_W = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COUNTERS - 1);

  if ((BASE_ADDR + N_COUNTERS > 256) || (N_COUNTERS < 1) || (TIMEOUT < 2)) begin : g_param_err
    $error("perf_scan_ctrl: BASE_ADDR+N_COUNTERS must be <= 256, N_COUNTERS >= 1, TIMEOUT >= 2");
  end

  scan_state_t            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  perf_rec_t              rec_q, rec_d;
  logic [PERF_ADDR_W-1:0] req_addr;
  logic [PERF_DATA_W-1:0] cap_data;
  logic                   tmr_load, tmr_count, tmr_expired;

  assign req_addr = PERF_ADDR_W'(BASE_ADDR) + PERF_ADDR_W'(idx_q);

  perf_scan_ctrl_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (tmr_load),
    .i_count   (tmr_count),
    .o_expired (tmr_expired)
  );

`ifdef PERF_SCAN_DELTA_EN
  logic [PERF_DATA_W-1:0] prev_q [N_COUNTERS];
  logic [PERF_DATA_W-1:0] cur_q, cur_d;

  assign cap_data = perf.data - prev_q[idx_q];

  // Raw value of the acked read, kept to become the next baseline.
  always_comb begin
    cur_d = cur_q;
    if ((state_q == WAIT) && perf.ack) cur_d = perf.data;
  end

  // Baseline per counter; only acked records move it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cur_q <= '0;
      for (int i = 0; i < N_COUNTERS; i++) prev_q[i] <= '0;
    end else begin
      cur_q <= cur_d;
      if ((state_q == EMIT) && i_ready && !rec_q.timeout) prev_q[idx_q] <= cur_q;
    end
  end
`else
  assign cap_data = perf.data;
`endif

  // Next-state, bus drive and stream outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rec_d     = rec_q;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    perf.stb  = 1'b0;
    perf.addr = '0;
    o_valid   = 1'b0;
    o_done    = 1'b0;
    o_busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (i_start) begin
          idx_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        perf.stb  = 1'b1;
        perf.addr = req_addr;
        if (!perf.stall) begin
          tmr_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (perf.ack) begin
          rec_d   = '{addr: req_addr, data: cap_data, timeout: 1'b0};
          state_d = EMIT;
        end else if (tmr_expired) begin
          rec_d   = '{addr: req_addr, data: '0, timeout: 1'b1};
          state_d = EMIT;
        end else begin
          tmr_count = 1'b1;
        end
      end
      EMIT: begin
        o_valid = 1'b1;
        if (i_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index and record registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rec_q   <= rec_d;
    end
  end

  assign o_addr    = rec_q.addr;
  assign o_data    = rec_q.data;
  assign o_timeout = rec_q.timeout;
endmodule

// File: tb/tb_perf_scan_ctrl.sv
module tb_perf_scan_ctrl;
  import perf_scan_ctrl_pkg::*;

  localparam int N    = 4;
  localparam int BASE = 8'h10;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        busy, done, valid, tmo_o;
  logic [7:0]  addr_o;
  logic [31:0] data_o;

  perf_scan_ctrl_if pif ();

  always #5 clk = ~clk;

  perf_scan_ctrl #(.N_COUNTERS(N), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_start   (start),
    .o_busy    (busy),
    .o_done    (done),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_addr    (addr_o),
    .o_data    (data_o),
    .o_timeout (tmo_o),
    .perf      (pif.master)
  );

  // Registered counter slave: acks one cycle after a non-stalled stb.
  logic [7:0]  missing  = 8'hFF;
  logic        stall_in = 1'b0;
  logic        inj_ack  = 1'b0;
  logic [31:0] inj_data = '0;
  logic        ovr_en   = 1'b0;
  logic [31:0] ovr_val  = '0;
  logic        slv_ack  = 1'b0;
  logic [31:0] slv_data = '0;

  always @(posedge clk) begin
    slv_ack  <= pif.stb && !pif.stall && (pif.addr != missing);
    slv_data <= (pif.stb && !pif.stall && (pif.addr != missing)) ?
                (ovr_en ? ovr_val : 32'(pif.addr) * 100) : '0;
  end
  assign pif.ack   = slv_ack | inj_ack;
  assign pif.data  = slv_data | inj_data;
  assign pif.stall = stall_in;

  // Record/event log.
  int          cyc = 0, hs_n = 0, done_n = 0, done_cyc = 0, stb_cyc = 0;
  logic [7:0]  log_addr [64];
  logic [31:0] log_data [64];
  logic        log_tmo  [64];
  int          log_cyc  [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid && ready && hs_n < 64) begin
      log_addr[hs_n] <= addr_o;
      log_data[hs_n] <= data_o;
      log_tmo[hs_n]  <= tmo_o;
      log_cyc[hs_n]  <= cyc;
      hs_n           <= hs_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (pif.stb) stb_cyc <= cyc;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

`ifdef PERF_SCAN_DELTA_EN
  logic [31:0] exp_prev [N];
`endif

  task automatic clear_model();
`ifdef PERF_SCAN_DELTA_EN
    for (int i = 0; i < N; i++) exp_prev[i] = '0;
`endif
  endtask

  // Compare logged record k against counter index i with raw slave value.
  task automatic check_rec(input string name, input int k, input int i,
                           input logic [31:0] raw, input logic t);
    logic [31:0] exp_d;
    exp_d = t ? 32'h0 : raw;
`ifdef PERF_SCAN_DELTA_EN
    if (!t) begin
      exp_d       = raw - exp_prev[i];
      exp_prev[i] = raw;
    end
`endif
    if (k >= 64) begin
      chk({name, "_logidx"}, 32'(k), 32'(63));
    end else begin
      chk({name, "_addr"}, 32'(log_addr[k]), 32'(BASE + i));
      chk({name, "_data"}, log_data[k], exp_d);
      chk({name, "_tmo"}, 32'(log_tmo[k]), 32'(t));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic pulse_start(output int c0, output int k0);
    @(negedge clk);
    start = 1'b1;
    c0    = cyc;
    k0    = hs_n;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0]       missing;
    logic [3:0][31:0] raw;
    logic [3:0]       tmo;
  } scan_vec_t;

  scan_vec_t vecs [3];

  initial begin
    int c0, k0, t, dn, exp_cyc;
    logic [7:0]  h_addr;
    logic [31:0] h_data;
    logic        h_tmo;

    vecs[0].missing = 8'hFF;
    vecs[0].raw     = {32'd1900, 32'd1800, 32'd1700, 32'd1600};
    vecs[0].tmo     = 4'b0000;
    vecs[1].missing = 8'h10;
    vecs[1].raw     = {32'd1900, 32'd1800, 32'd1700, 32'd0};
    vecs[1].tmo     = 4'b0001;
    vecs[2].missing = 8'h13;
    vecs[2].raw     = {32'd0, 32'd1800, 32'd1700, 32'd1600};
    vecs[2].tmo     = 4'b1000;

    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_addr", 32'(addr_o), 0);
    chk("rst_data", data_o, 0);
    chk("rst_tmo", 32'(tmo_o), 0);
    chk("rst_stb", 32'(pif.stb), 0);
    chk("rst_paddr", 32'(pif.addr), 0);

    // Table-driven full scans with latency model.
    for (int v = 0; v < 3; v++) begin
      missing = vecs[v].missing;
      dn = done_n;
      pulse_start(c0, k0);
      wait_done($sformatf("v%0d_done", v));
      @(negedge clk);
      chk($sformatf("v%0d_nrec", v), 32'(hs_n - k0), 32'(N));
      chk($sformatf("v%0d_ndone", v), 32'(done_n - dn), 1);
      exp_cyc = c0;
      for (int i = 0; i < N; i++) begin
        exp_cyc = exp_cyc + 1 + (vecs[v].tmo[i] ? TMO + 1 : 2);
        check_rec($sformatf("v%0d_r%0d", v, i), k0 + i, i, vecs[v].raw[i], vecs[v].tmo[i]);
        if (k0 + i < 64) chk($sformatf("v%0d_r%0d_cyc", v, i), 32'(log_cyc[k0 + i]), 32'(exp_cyc));
      end
      chk($sformatf("v%0d_done_cyc", v), 32'(done_cyc), 32'(exp_cyc + 1));
    end
    missing = 8'hFF;

    // Timeout at 0x12 with a late ack while the record waits in EMIT.
    missing = 8'h12;
    pulse_start(c0, k0);
    t = 0;
    while (!(valid && addr_o == 8'h12) && t < 200) begin
      @(negedge clk);
      t++;
    end
    ready = 1'b0;
    chk("to_seen", 32'(valid && addr_o == 8'h12), 1);
    chk("to_latency", 32'(cyc - stb_cyc), 32'(TMO + 1));
    repeat (2) @(negedge clk);
    inj_ack  = 1'b1;
    inj_data = 32'hDEAD_BEEF;
    @(negedge clk);
    inj_ack  = 1'b0;
    inj_data = '0;
    @(negedge clk);
    chk("late_ack_valid", 32'(valid), 1);
    chk("late_ack_addr", 32'(addr_o), 32'h12);
    chk("late_ack_data", data_o, 0);
    chk("late_ack_tmo", 32'(tmo_o), 1);
    ready = 1'b1;
    wait_done("to_done");
    @(negedge clk);
    missing = 8'hFF;
    chk("to_nrec", 32'(hs_n - k0), 32'(N));
    check_rec("to_r0", k0, 0, 32'd1600, 1'b0);
    check_rec("to_r1", k0 + 1, 1, 32'd1700, 1'b0);
    check_rec("to_r2", k0 + 2, 2, 32'd0, 1'b1);
    check_rec("to_r3", k0 + 3, 3, 32'd1900, 1'b0);

    // Stall: 5 stalled cycles keep stb and addr for 6 cycles.
    pulse_start(c0, k0);
    t = 0;
    while (!pif.stb && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("stall_stb_first", 32'(pif.stb), 1);
    stall_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_stb_%0d", i), 32'(pif.stb), 1);
      chk($sformatf("stall_addr_%0d", i), 32'(pif.addr), 32'h10);
      if (i == 5) stall_in = 1'b0;
    end
    @(negedge clk);
    chk("stall_released", 32'(pif.stb), 0);
    wait_done("stall_done");
    @(negedge clk);
    chk("stall_nrec", 32'(hs_n - k0), 32'(N));
    for (int i = 0; i < N; i++)
      check_rec($sformatf("stall_r%0d", i), k0 + i, i, 32'((BASE + i) * 100), 1'b0);

    // Back-pressure: record held stable, starts while busy ignored.
    ready = 1'b0;
    dn = done_n;
    pulse_start(c0, k0);
    t = 0;
    while (!valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    h_addr = addr_o;
    h_data = data_o;
    h_tmo  = tmo_o;
    chk("bp_first_addr", 32'(h_addr), 32'h10);
    for (int i = 0; i < 10; i++) begin
      start = (i == 2 || i == 5);
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i), 32'(valid), 1);
      chk($sformatf("bp_addr_%0d", i), 32'(addr_o), 32'(h_addr));
      chk($sformatf("bp_data_%0d", i), data_o, h_data);
      chk($sformatf("bp_tmo_%0d", i), 32'(tmo_o), 32'(h_tmo));
    end
    start = 1'b0;
    ready = 1'b1;
    wait_done("bp_done");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done_busy0", 32'(busy), 0);
    @(negedge clk);
    chk("start_at_done_busy1", 32'(busy), 0);
    chk("bp_nrec", 32'(hs_n - k0), 32'(N));
    chk("bp_ndone", 32'(done_n - dn), 1);
    for (int i = 0; i < N; i++)
      check_rec($sformatf("bp_r%0d", i), k0 + i, i, 32'((BASE + i) * 100), 1'b0);

    // Reset in WAIT of the second record.
    pulse_start(c0, k0);
    t = 0;
    while (!(pif.stb && pif.addr == 8'h11) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("mid_rst_reach", 32'(pif.stb && pif.addr == 8'h11), 1);
    @(negedge clk);
    rst = 1'b1;
    dn  = done_n;
    @(negedge clk);
    chk("mid_rst_stb", 32'(pif.stb), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_addr", 32'(addr_o), 0);
    rst = 1'b0;
    clear_model();
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_n - dn), 0);
    pulse_start(c0, k0);
    wait_done("post_rst_done");
    @(negedge clk);
    chk("post_rst_nrec", 32'(hs_n - k0), 32'(N));
    for (int i = 0; i < N; i++)
      check_rec($sformatf("post_rst_r%0d", i), k0 + i, i, 32'((BASE + i) * 100), 1'b0);

`ifdef PERF_SCAN_DELTA_EN
    // Delta wraps modulo 2^32 across two scans.
    do_reset();
    ovr_en  = 1'b1;
    ovr_val = 32'hFFFF_FFF0;
    pulse_start(c0, k0);
    wait_done("delta1_done");
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (k0 + i < 64) chk($sformatf("delta1_r%0d", i), log_data[k0 + i], 32'hFFFF_FFF0);
    ovr_val = 32'h0000_0010;
    pulse_start(c0, k0);
    wait_done("delta2_done");
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (k0 + i < 64) chk($sformatf("delta2_r%0d", i), log_data[k0 + i], 32'h0000_0020);
    ovr_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
